// File: rtl/spi_multi_sensor_poller_pkg.sv
// Shared types and helpers for the multi-sensor SPI poller.
// Holds the FSM state encoding and a width helper that never returns zero.
package spi_multi_sensor_poller_pkg;

  typedef enum logic [2:0] {IDLE, SEL, SETUP, SHIFT, HOLD} spi_poll_state_e;

  function automatic int unsigned clog2_min1(input int unsigned n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/spi_multi_sensor_poller_rx_shifter.sv
// SCK generator plus MSB-first receive shift register for one CS-low frame.
// A start pulse runs FRAME_BITS SCK periods: SCK_DIV cycles high, then SCK_DIV cycles low.
module spi_rx_shifter
  import spi_multi_sensor_poller_pkg::*;
#(
  parameter int unsigned FRAME_BITS = 16,
  parameter int unsigned SCK_DIV    = 5
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  start_i,
  input  logic                  miso_i,
  output logic                  sck_o,
  output logic [FRAME_BITS-1:0] frame_o,
  output logic                  done_o
);

  localparam int unsigned DIV_W = clog2_min1(SCK_DIV);
  localparam int unsigned BIT_W = clog2_min1(FRAME_BITS);
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SCK_DIV - 1);
  localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(FRAME_BITS - 1);

  logic             active;
  logic             sck;
  logic [DIV_W-1:0] div_cnt;
  logic [BIT_W-1:0] bit_cnt;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      active  <= 1'b0;
      sck     <= 1'b0;
      div_cnt <= '0;
      bit_cnt <= '0;
      frame_o <= '0;
    end else if (start_i) begin
      active  <= 1'b1;
      sck     <= 1'b1;
      div_cnt <= '0;
      bit_cnt <= '0;
    end else if (active) begin
      // MISO is taken in the first clk cycle of each SCK high half
      if (sck && div_cnt == '0)
        frame_o <= {frame_o[FRAME_BITS-2:0], miso_i};
      if (div_cnt == DIV_LAST) begin
        div_cnt <= '0;
        if (sck)
          sck <= 1'b0;
        else if (bit_cnt == BIT_LAST)
          active <= 1'b0;
        else begin
          bit_cnt <= bit_cnt + 1'b1;
          sck     <= 1'b1;
        end
      end else begin
        div_cnt <= div_cnt + 1'b1;
      end
    end
  end

  assign sck_o  = sck;
  assign done_o = active && !sck && (div_cnt == DIV_LAST) && (bit_cnt == BIT_LAST);

endmodule

// File: rtl/spi_multi_sensor_poller.sv
// Autonomous SPI master polling NUM_CH read-only sensors on shared SCK/MISO.
// Scans run on a period tick or trigger; each channel keeps a result and a new flag.
module spi_multi_sensor_poller
  import spi_multi_sensor_poller_pkg::*;
#(
  parameter int unsigned NUM_CH        = 2,
  parameter int unsigned FRAME_BITS    = 16,
  parameter int unsigned DATA_MSB      = 12,
  parameter int unsigned DATA_LSB      = 5,
  parameter int unsigned SCK_DIV       = 5,
  parameter int unsigned CS_SETUP      = 2,
  parameter int unsigned CS_HOLD       = 2,
  parameter int unsigned SAMPLE_PERIOD = 1_000_000,
  localparam int unsigned DW   = DATA_MSB - DATA_LSB + 1,
  localparam int unsigned CH_W = clog2_min1(NUM_CH)
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              en_i,
  input  logic              trigger_i,
  input  logic [NUM_CH-1:0] ch_mask_i,
  input  logic              miso_i,
  output logic              sck_o,
  output logic              mosi_o,
  output logic [NUM_CH-1:0] cs_n_o,
  input  logic [CH_W-1:0]   rd_ch_i,
  output logic [DW-1:0]     rd_data_o,
  output logic              rd_new_o,
  input  logic              rd_ack_i,
  output logic              busy_o,
  output logic              sample_done_o,
  output logic              overrun_o
);

  localparam int unsigned PER_W = clog2_min1(SAMPLE_PERIOD);
  localparam int unsigned TMR_W = clog2_min1(((CS_SETUP > CS_HOLD) ? CS_SETUP : CS_HOLD) + 1);

  spi_poll_state_e state, state_nxt;

  logic [PER_W-1:0]      per_cnt;
  logic                  tick;
  logic                  pend;
  logic                  start;
  logic [TMR_W-1:0]      tmr;
  logic                  setup_last;
  logic                  hold_last;
  logic [NUM_CH-1:0]     rem;
  logic [CH_W-1:0]       cur_ch;
  logic                  sel_found;
  logic [CH_W-1:0]       sel_idx;
  logic                  sh_start;
  logic                  sh_done;
  logic [FRAME_BITS-1:0] sh_frame;
  logic                  wr_en;
  logic [DW-1:0]         res [NUM_CH];
  logic [NUM_CH-1:0]     new_flag;
  logic                  frame_unused;

  spi_rx_shifter #(
    .FRAME_BITS (FRAME_BITS),
    .SCK_DIV    (SCK_DIV)
  ) u_shifter (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .start_i (sh_start),
    .miso_i  (miso_i),
    .sck_o   (sck_o),
    .frame_o (sh_frame),
    .done_o  (sh_done)
  );

  assign frame_unused = ^sh_frame;
  assign mosi_o       = 1'b0;

  assign tick       = en_i && (per_cnt == PER_W'(SAMPLE_PERIOD - 1));
  assign start      = tick || trigger_i || pend;
  assign setup_last = (tmr == TMR_W'(CS_SETUP - 1));
  assign hold_last  = (tmr == TMR_W'(CS_HOLD - 1));

  always_ff @(posedge clk_i) begin
    if (rst_i || !en_i)
      per_cnt <= '0;
    else if (tick)
      per_cnt <= '0;
    else
      per_cnt <= per_cnt + 1'b1;
  end

  // A trigger seen outside IDLE is remembered once; IDLE consumes it
  always_ff @(posedge clk_i) begin
    if (rst_i || state == IDLE)
      pend <= 1'b0;
    else if (trigger_i)
      pend <= 1'b1;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i)
      overrun_o <= 1'b0;
    else if (tick && state != IDLE)
      overrun_o <= 1'b1;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i)
      state <= IDLE;
    else
      state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = SEL;
      SEL:     state_nxt = sel_found ? SETUP : IDLE;
      SETUP:   if (setup_last) state_nxt = SHIFT;
      SHIFT:   if (sh_done) state_nxt = HOLD;
      HOLD:    if (hold_last) state_nxt = SEL;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    busy_o        = (state != IDLE);
    sample_done_o = (state == SEL) && !sel_found;
    sh_start      = (state == SETUP) && setup_last;
    wr_en         = (state == HOLD) && hold_last;
    cs_n_o        = '1;
    if (state == SETUP || state == SHIFT || state == HOLD) begin
      for (int unsigned i = 0; i < NUM_CH; i++)
        if (cur_ch == CH_W'(i)) cs_n_o[i] = 1'b0;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i || state_nxt != state || (state != SETUP && state != HOLD))
      tmr <= '0;
    else
      tmr <= tmr + 1'b1;
  end

  always_comb begin
    sel_found = 1'b0;
    sel_idx   = '0;
    for (int unsigned i = 0; i < NUM_CH; i++) begin
      if (rem[i] && !sel_found) begin
        sel_found = 1'b1;
        sel_idx   = CH_W'(i);
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      rem    <= '0;
      cur_ch <= '0;
    end else if (state == IDLE && start) begin
      rem <= ch_mask_i;
    end else if (state == SEL && sel_found) begin
      cur_ch <= sel_idx;
      for (int unsigned i = 0; i < NUM_CH; i++)
        if (sel_idx == CH_W'(i)) rem[i] <= 1'b0;
    end
  end

  // Result write is placed after the ack so it wins on the same channel
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      for (int unsigned i = 0; i < NUM_CH; i++) res[i] <= '0;
      new_flag <= '0;
    end else begin
      for (int unsigned i = 0; i < NUM_CH; i++) begin
        if (rd_ack_i && rd_ch_i == CH_W'(i))
          new_flag[i] <= 1'b0;
        if (wr_en && cur_ch == CH_W'(i)) begin
          res[i]      <= sh_frame[DATA_MSB:DATA_LSB];
          new_flag[i] <= 1'b1;
        end
      end
    end
  end

  always_comb begin
    rd_data_o = '0;
    rd_new_o  = 1'b0;
    for (int unsigned i = 0; i < NUM_CH; i++) begin
      if (rd_ch_i == CH_W'(i)) begin
        rd_data_o = res[i];
        rd_new_o  = new_flag[i];
      end
    end
  end

endmodule

// File: tb/tb_spi_multi_sensor_poller.sv
// Directed self-checking bench for spi_multi_sensor_poller with two sensor models.
// A second instance with a short sample period exercises overrun and back-to-back scans.
module tb_spi_multi_sensor_poller;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       en = 1'b0, trig = 1'b0, rd_ack = 1'b0;
  logic [1:0] mask = 2'b11;
  logic [0:0] rd_ch = 1'b0;
  logic       miso, sck, mosi, rd_new, busy, done, overrun;
  logic [1:0] cs_n;
  logic [7:0] rd_data;

  logic       en_f = 1'b0, trig_f = 1'b0, miso_f = 1'b0, rd_ack_f = 1'b0;
  logic [1:0] mask_f = 2'b11;
  logic [0:0] rd_ch_f = 1'b0;
  logic       sck_f, mosi_f, rd_new_f, busy_f, done_f, overrun_f;
  logic [1:0] cs_n_f;
  logic [7:0] rd_data_f;

  int n_cmp = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  spi_multi_sensor_poller #(
    .NUM_CH(2), .FRAME_BITS(16), .DATA_MSB(12), .DATA_LSB(5), .SCK_DIV(5),
    .CS_SETUP(2), .CS_HOLD(2), .SAMPLE_PERIOD(2000)
  ) u_dut (
    .clk_i(clk), .rst_i(rst), .en_i(en), .trigger_i(trig), .ch_mask_i(mask),
    .miso_i(miso), .sck_o(sck), .mosi_o(mosi), .cs_n_o(cs_n), .rd_ch_i(rd_ch),
    .rd_data_o(rd_data), .rd_new_o(rd_new), .rd_ack_i(rd_ack), .busy_o(busy),
    .sample_done_o(done), .overrun_o(overrun)
  );

  spi_multi_sensor_poller #(
    .NUM_CH(2), .FRAME_BITS(16), .DATA_MSB(12), .DATA_LSB(5), .SCK_DIV(5),
    .CS_SETUP(2), .CS_HOLD(2), .SAMPLE_PERIOD(200)
  ) u_dut_fast (
    .clk_i(clk), .rst_i(rst), .en_i(en_f), .trigger_i(trig_f), .ch_mask_i(mask_f),
    .miso_i(miso_f), .sck_o(sck_f), .mosi_o(mosi_f), .cs_n_o(cs_n_f), .rd_ch_i(rd_ch_f),
    .rd_data_o(rd_data_f), .rd_new_o(rd_new_f), .rd_ack_i(rd_ack_f), .busy_o(busy_f),
    .sample_done_o(done_f), .overrun_o(overrun_f)
  );

  // Sensor models: preload while deselected, shift on each observed SCK fall
  logic [15:0] sh0 = 16'h0FE0, sh1 = 16'h1FE0;
  logic        sck_prev = 1'b0;
  always @(posedge clk) begin
    sck_prev <= sck;
    if (cs_n[0]) sh0 <= 16'h0FE0;
    else if (sck_prev && !sck) sh0 <= {sh0[14:0], 1'b0};
    if (cs_n[1]) sh1 <= 16'h1FE0;
    else if (sck_prev && !sck) sh1 <= {sh1[14:0], 1'b0};
  end
  assign miso = !cs_n[0] ? sh0[15] : (!cs_n[1] ? sh1[15] : 1'b0);

  int run0 = 0, run1 = 0, len0 = 0, len1 = 0, falls0 = 0, falls1 = 0;
  int rises = 0, done_f_cnt = 0;
  logic [1:0] cs_prev = 2'b11;
  logic overlap = 1'b0;
  always @(posedge clk) begin
    cs_prev <= cs_n;
    if (!cs_n[0]) run0 <= run0 + 1;
    else if (run0 != 0) begin len0 <= run0; run0 <= 0; end
    if (!cs_n[1]) run1 <= run1 + 1;
    else if (run1 != 0) begin len1 <= run1; run1 <= 0; end
    if (cs_prev[0] && !cs_n[0]) falls0 <= falls0 + 1;
    if (cs_prev[1] && !cs_n[1]) falls1 <= falls1 + 1;
    if (cs_n == 2'b00) overlap <= 1'b1;
    if (!sck_prev && sck) rises <= rises + 1;
    if (done_f) done_f_cnt <= done_f_cnt + 1;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic rd(input logic ch);
    rd_ch = ch; #1;
  endtask

  // Pulses trigger for one cycle and counts cycles until sample_done_o
  task automatic run_scan(input int maxc, output int n);
    trig = 1'b1;
    n = 0;
    do begin step(1); trig = 1'b0; n++; end while (!done && n < maxc);
    chk("scan_done_seen", done, 1'b1);
  endtask

  task automatic wait_done(input int maxc, output int n);
    n = 0;
    do begin step(1); n++; end while (!done && n < maxc);
    chk("period_done_seen", done, 1'b1);
  endtask

  task automatic wait_done_f(input int maxc);
    int n = 0;
    do begin step(1); n++; end while (!done_f && n < maxc);
    chk("fast_done_seen", done_f, 1'b1);
  endtask

  initial begin
    int n, f0, f1, r0, d0;

    // Reset state
    step(3);
    chk("rst_sck", sck, 1'b0);
    chk("rst_mosi", mosi, 1'b0);
    chk("rst_cs", cs_n, 2'b11);
    chk("rst_busy", busy, 1'b0);
    chk("rst_done", done, 1'b0);
    chk("rst_overrun", overrun, 1'b0);
    rd(0); chk("rst_data0", rd_data, 8'h00); chk("rst_new0", rd_new, 1'b0);
    rst = 1'b0;
    step(2);

    // 1: triggered scan of both channels
    f0 = falls0; f1 = falls1;
    mask = 2'b11;
    run_scan(500, n);
    chk("t1_latency", n, 331);
    step(1);
    chk("t1_len0", len0, 164);
    chk("t1_len1", len1, 164);
    chk("t1_falls0", falls0 - f0, 1);
    chk("t1_falls1", falls1 - f1, 1);
    chk("t1_overlap", overlap, 1'b0);
    chk("t1_busy_after", busy, 1'b0);
    rd(0); chk("t1_data0", rd_data, 8'h7F); chk("t1_new0", rd_new, 1'b1);
    rd(1); chk("t1_data1", rd_data, 8'hFF); chk("t1_new1", rd_new, 1'b1);

    // 2: ack then periodic scans
    rd(0); rd_ack = 1'b1; step(1); rd_ack = 1'b0;
    chk("t2_ack_new0", rd_new, 1'b0);
    rd(1); chk("t2_new1_kept", rd_new, 1'b1);
    en = 1'b1;
    wait_done(2600, n);
    chk("t2_first_period", n, 2330);
    wait_done(2600, n);
    chk("t2_period", n, 2000);
    en = 1'b0;
    chk("t2_overrun", overrun, 1'b0);
    rd(0); chk("t2_new0_again", rd_new, 1'b1);
    step(2);

    // 3: only channel 1
    rd(0); rd_ack = 1'b1; step(1);
    rd(1); step(1); rd_ack = 1'b0;
    f0 = falls0; f1 = falls1;
    mask = 2'b10;
    run_scan(500, n);
    chk("t3_latency", n, 166);
    step(1);
    chk("t3_falls0", falls0 - f0, 0);
    chk("t3_falls1", falls1 - f1, 1);
    rd(0); chk("t3_data0", rd_data, 8'h7F); chk("t3_new0", rd_new, 1'b0);
    rd(1); chk("t3_data1", rd_data, 8'hFF); chk("t3_new1", rd_new, 1'b1);

    // 4: empty mask
    f0 = falls0; f1 = falls1; r0 = rises;
    mask = 2'b00;
    run_scan(10, n);
    chk("t4_latency", n, 1);
    chk("t4_cs", cs_n, 2'b11);
    step(2);
    chk("t4_falls", (falls0 - f0) + (falls1 - f1), 0);
    chk("t4_rises", rises - r0, 0);
    chk("t4_sck", sck, 1'b0);

    // 5: short period - overrun and one back-to-back scan from a trigger
    en_f = 1'b1;
    n = 0;
    do begin step(1); n++; end while (!busy_f && n < 300);
    chk("t5_first_busy", n, 200);
    step(10);
    trig_f = 1'b1; step(1); trig_f = 1'b0;
    n = 0;
    do begin step(1); n++; end while (!overrun_f && n < 400);
    chk("t5_overrun_set", overrun_f, 1'b1);
    en_f = 1'b0;
    d0 = done_f_cnt;
    wait_done_f(400);
    step(1); chk("t5_idle_gap", busy_f, 1'b0);
    step(1); chk("t5_rescan", busy_f, 1'b1);
    wait_done_f(400);
    step(20);
    chk("t5_stays_idle", busy_f, 1'b0);
    chk("t5_done_count", done_f_cnt - d0, 2);
    chk("t5_overrun_sticky", overrun_f, 1'b1);

    // 6: reset in the middle of channel 0's frame
    mask = 2'b11;
    r0 = rises;
    trig = 1'b1; step(1); trig = 1'b0;
    n = 0;
    while (rises - r0 < 7 && n < 300) begin step(1); n++; end
    chk("t6_reach_edge7", rises - r0, 7);
    rst = 1'b1; step(1);
    chk("t6_cs", cs_n, 2'b11);
    chk("t6_sck", sck, 1'b0);
    chk("t6_busy", busy, 1'b0);
    rd(0); chk("t6_data0", rd_data, 8'h00); chk("t6_new0", rd_new, 1'b0);
    rd(1); chk("t6_data1", rd_data, 8'h00); chk("t6_new1", rd_new, 1'b0);
    rst = 1'b0;
    step(2);
    run_scan(500, n);
    chk("t6_latency", n, 331);
    rd(0); chk("t6_redo_data0", rd_data, 8'h7F); chk("t6_redo_new0", rd_new, 1'b1);
    rd(1); chk("t6_redo_data1", rd_data, 8'hFF);
    chk("t6_overlap", overlap, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: observed no completion, expected finish before time limit");
    $fatal(1, "watchdog expired");
  end

endmodule
